// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Holds the FSM state encoding and the column rotation helpers.
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_e;

    localparam logic [NUM_COLS-1:0] COL_RESET = 4'b0001;

    function automatic logic is_onehot(input logic [NUM_ROWS-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

    function automatic logic [NUM_COLS-1:0] rotl(input logic [NUM_COLS-1:0] c);
        return {c[NUM_COLS-2:0], c[NUM_COLS-1]};
    endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// Free-running column-slot divider: counts 0..SCAN_DIV-1 and asserts a
// one-cycle tick on the last count of each slot.
module keypad_tick_gen #(
    parameter int SCAN_DIV = 1000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_o
);

    localparam int W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(SCAN_DIV - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tick_o = (cnt_q == LAST);
    assign cnt_d  = tick_o ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: rotates the column drive, synchronises and debounces
// the rows, and presents one accepted {row,col} pair with a press strobe.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_ROWS-1:0] row_in,
    output logic [NUM_COLS-1:0] col_drive,
    output logic [NUM_ROWS-1:0] key_row,
    output logic [NUM_COLS-1:0] key_col,
    output logic                key_press,
    output logic                key_held
);

    localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1) + 1;
    // The capture sample already counts as the first match, so the final
    // matching tick arrives while the counter still reads DEBOUNCE_CNT-1.
    localparam logic [CNT_W-1:0] ACCEPT_AT = CNT_W'(DEBOUNCE_CNT - 1);

    logic                tick;
    logic [NUM_ROWS-1:0] row_meta_q;
    logic [NUM_ROWS-1:0] row_sync_q;
    logic [NUM_ROWS-1:0] sample;

    state_e              state_q,    state_d;
    logic [NUM_COLS-1:0] col_q,      col_d;
    logic [NUM_ROWS-1:0] cand_row_q, cand_row_d;
    logic [NUM_COLS-1:0] cand_col_q, cand_col_d;
    logic [CNT_W-1:0]    cnt_q,      cnt_d;
    logic [NUM_ROWS-1:0] key_row_q,  key_row_d;
    logic [NUM_COLS-1:0] key_col_q,  key_col_d;
    logic                press_q,    press_d;
    logic                held_q,     held_d;

    keypad_tick_gen #(
        .SCAN_DIV (SCAN_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick_o (tick)
    );

    assign sample = row_sync_q;

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        cand_row_d = cand_row_q;
        cand_col_d = cand_col_q;
        cnt_d      = cnt_q;
        key_row_d  = key_row_q;
        key_col_d  = key_col_q;
        press_d    = 1'b0;
        held_d     = held_q;

        if (tick) begin
            unique case (state_q)
                SCAN: begin
                    if (is_onehot(sample)) begin
                        cand_row_d = sample;
                        cand_col_d = col_q;
                        cnt_d      = CNT_W'(1);
                        state_d    = DEBOUNCE;
                    end else begin
                        col_d = rotl(col_q);
                    end
                end
                DEBOUNCE: begin
                    if (sample == cand_row_q) begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q >= ACCEPT_AT) begin
                            key_row_d = cand_row_q;
                            key_col_d = cand_col_q;
                            press_d   = 1'b1;
                            held_d    = 1'b1;
                            state_d   = HELD;
                        end
                    end else begin
                        cnt_d   = '0;
                        col_d   = rotl(col_q);
                        state_d = SCAN;
                    end
                end
                HELD: begin
                    if (sample != key_row_q) begin
                        cnt_d   = CNT_W'(1);
                        state_d = RELEASE;
                    end
                end
                RELEASE: begin
                    if (sample == '0) begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q >= ACCEPT_AT) begin
                            cnt_d   = '0;
                            held_d  = 1'b0;
                            state_d = SCAN;
                        end
                    end else if (sample == key_row_q) begin
                        state_d = HELD;
                    end else begin
                        cnt_d = '0;
                    end
                end
                default: state_d = SCAN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta_q <= '0;
            row_sync_q <= '0;
            state_q    <= SCAN;
            col_q      <= COL_RESET;
            cand_row_q <= '0;
            cand_col_q <= '0;
            cnt_q      <= '0;
            key_row_q  <= '0;
            key_col_q  <= '0;
            press_q    <= 1'b0;
            held_q     <= 1'b0;
        end else begin
            row_meta_q <= row_in;
            row_sync_q <= row_meta_q;
            state_q    <= state_d;
            col_q      <= col_d;
            cand_row_q <= cand_row_d;
            cand_col_q <= cand_col_d;
            cnt_q      <= cnt_d;
            key_row_q  <= key_row_d;
            key_col_q  <= key_col_d;
            press_q    <= press_d;
            held_q     <= held_d;
        end
    end

    assign col_drive = col_q;
    assign key_row   = key_row_q;
    assign key_col   = key_col_q;
    assign key_press = press_q;
    assign key_held  = held_q;

endmodule
